// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types: writeback-select encoding and the MEM->WB payload.
package otter_pipe_pkg;

    localparam int OTTER_XLEN    = 32;
    localparam int OTTER_RADDR_W = 5;

    // Writeback source select; 2'b11 is reserved and yields a zero result.
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // Fields carried from the memory stage into writeback.
    typedef struct packed {
        logic                     regwrite;
        result_src_e              result_src;
        logic [OTTER_XLEN-1:0]    alu_result;
        logic [OTTER_XLEN-1:0]    read_data;
        logic [OTTER_RADDR_W-1:0] rd;
        logic [OTTER_XLEN-1:0]    pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// MEM->WB boundary bundle: pipeline control, M-stage inputs and W-stage outputs.
interface mem_wb_pipe_reg_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
);
    logic               STALL;
    logic               FLUSH;
    logic               ValidM;
    logic               RegWriteM;
    logic [1:0]         ResultSrcM;
    logic [XLEN-1:0]    ALUResultM;
    logic [XLEN-1:0]    ReadDataM;
    logic [RADDR_W-1:0] RdM;
    logic [XLEN-1:0]    PCPlus4M;

    logic               ValidW;
    logic               RegWriteW;
    logic [1:0]         ResultSrcW;
    logic [RADDR_W-1:0] RdW;
    logic [XLEN-1:0]    ResultW;
    logic [CNT_W-1:0]   RetireCnt;

    // Memory stage / hazard unit side.
    modport master (
        output STALL, FLUSH, ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M,
        input  ValidW, RegWriteW, ResultSrcW, RdW, ResultW, RetireCnt
    );

    // Pipeline register side.
    modport slave (
        input  STALL, FLUSH, ValidM, RegWriteM, ResultSrcM, ALUResultM, ReadDataM, RdM, PCPlus4M,
        output ValidW, RegWriteW, ResultSrcW, RdW, ResultW, RetireCnt
    );
endinterface

// File: rtl/pipe_ctr.sv
// Free-running performance counter with synchronous clear and enable; wraps modulo 2^W.
module pipe_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Clear beats enable; the count rolls over naturally at the top of its range.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: captures M-stage payload with reset/flush/stall priority,
// qualifies the register-file write, muxes the writeback value and counts retirements.
// Payload field widths come from otter_pipe_pkg; XLEN/RADDR_W must agree with it.
module mem_wb_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    mem_wb_pipe_reg_if.slave bus
);
    import otter_pipe_pkg::*;

    mem_wb_t            m_d;
    mem_wb_t            w_q;
    logic               valid_q;
    logic [RADDR_W-1:0] rd_w;
    logic [XLEN-1:0]    result_w;
    logic               load_en;

    // A real load happens only when neither flush nor stall is active.
    assign load_en = !bus.FLUSH && !bus.STALL;

    // Pack the M-stage inputs into the stage payload.
    always_comb begin
        // NOTE: default the whole struct first so no field can hold over and infer a latch.
        m_d            = '0;
        m_d.regwrite   = bus.RegWriteM;
        m_d.result_src = result_src_e'(bus.ResultSrcM);
        m_d.alu_result = bus.ALUResultM;
        m_d.read_data  = bus.ReadDataM;
        m_d.rd         = bus.RdM;
        m_d.pc_plus4   = bus.PCPlus4M;
    end

    // Stage register: reset, then flush (bubble), then stall (hold), else capture.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking so payload and valid both sample pre-edge values together.
        if (RST) begin
            valid_q <= 1'b0;
            w_q     <= '0;
        end else if (bus.FLUSH) begin
            valid_q <= 1'b0;
            w_q     <= '0;
        end else if (!bus.STALL) begin
            valid_q <= bus.ValidM;
            w_q     <= m_d;
        end
    end

    // Writeback select on registered fields only; the reserved code reads as zero.
    always_comb begin
        result_w = '0;
        case (w_q.result_src)
            RES_ALU: result_w = w_q.alu_result;
            RES_MEM: result_w = w_q.read_data;
            RES_PC4: result_w = w_q.pc_plus4;
            default: result_w = '0;
        endcase
    end

    assign rd_w           = w_q.rd;
    assign bus.ValidW     = valid_q;
    assign bus.RdW        = rd_w;
    assign bus.ResultSrcW = w_q.result_src;
    assign bus.ResultW    = result_w;
    // Bubbles and writes to x0 never reach the register file.
    assign bus.RegWriteW  = w_q.regwrite && valid_q && (rd_w != '0);

    // Counts every valid instruction entering W; the bump lands on the same edge.
    pipe_ctr #(
        .W (CNT_W)
    ) u_retire_ctr (
        .clk (CLK),
        .clr (RST),
        .en  (load_en && bus.ValidM),
        .cnt (bus.RetireCnt)
    );

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg: directed vector table, counter-wrap sequence,
// and randomized traffic against a behavioural model. A second instance with a 4-bit
// counter shares all stimulus so wrap-around is visible throughout.
module tb_mem_wb_pipe_reg;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    mem_wb_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) u_if ();
    mem_wb_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .CNT_W(4))  u_if4 ();

    mem_wb_pipe_reg #(.XLEN(32), .RADDR_W(5), .CNT_W(32)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if.slave)
    );

    mem_wb_pipe_reg #(.XLEN(32), .RADDR_W(5), .CNT_W(4)) u_dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (u_if4.slave)
    );

    assign u_if4.STALL      = u_if.STALL;
    assign u_if4.FLUSH      = u_if.FLUSH;
    assign u_if4.ValidM     = u_if.ValidM;
    assign u_if4.RegWriteM  = u_if.RegWriteM;
    assign u_if4.ResultSrcM = u_if.ResultSrcM;
    assign u_if4.ALUResultM = u_if.ALUResultM;
    assign u_if4.ReadDataM  = u_if.ReadDataM;
    assign u_if4.RdM        = u_if.RdM;
    assign u_if4.PCPlus4M   = u_if.PCPlus4M;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        stall;
        logic        valid;
        logic        regwrite;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        exp_valid;
        logic        exp_regwrite;
        logic [4:0]  exp_rd;
        logic [31:0] exp_result;
        logic [31:0] exp_cnt;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic flush, input logic stall, input logic valid,
        input logic regwrite, input logic [1:0] src, input logic [31:0] alu,
        input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] pc4,
        input logic exp_valid, input logic exp_regwrite, input logic [4:0] exp_rd,
        input logic [31:0] exp_result, input logic [31:0] exp_cnt);
        vec_t v;
        v.rst = rst; v.flush = flush; v.stall = stall; v.valid = valid;
        v.regwrite = regwrite; v.src = src; v.alu = alu; v.rdata = rdata;
        v.rd = rd; v.pc4 = pc4;
        v.exp_valid = exp_valid; v.exp_regwrite = exp_regwrite; v.exp_rd = exp_rd;
        v.exp_result = exp_result; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic flush, input logic stall, input logic valid,
                         input logic regwrite, input logic [1:0] src, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] pc4);
        RST             = rst;
        u_if.FLUSH      = flush;
        u_if.STALL      = stall;
        u_if.ValidM     = valid;
        u_if.RegWriteM  = regwrite;
        u_if.ResultSrcM = src;
        u_if.ALUResultM = alu;
        u_if.ReadDataM  = rdata;
        u_if.RdM        = rd;
        u_if.PCPlus4M   = pc4;
    endtask

    // Behavioural model: the W stage as a set of plain variables plus a retirement tally.
    logic        ref_valid;
    logic        ref_regwrite;
    logic [1:0]  ref_src;
    logic [31:0] ref_alu;
    logic [31:0] ref_rdata;
    logic [4:0]  ref_rd;
    logic [31:0] ref_pc4;
    longint      ref_retired;

    task automatic model_edge();
        if (RST || u_if.FLUSH) begin
            ref_valid = 1'b0; ref_regwrite = 1'b0; ref_src = 2'd0; ref_alu = '0;
            ref_rdata = '0; ref_rd = '0; ref_pc4 = '0;
            if (RST) ref_retired = 0;
        end else if (!u_if.STALL) begin
            ref_valid    = u_if.ValidM;
            ref_regwrite = u_if.RegWriteM;
            ref_src      = u_if.ResultSrcM;
            ref_alu      = u_if.ALUResultM;
            ref_rdata    = u_if.ReadDataM;
            ref_rd       = u_if.RdM;
            ref_pc4      = u_if.PCPlus4M;
            if (u_if.ValidM) ref_retired = ref_retired + 1;
        end
    endtask

    task automatic model_compare(input string tag);
        logic [31:0] exp_res;
        exp_res = (ref_src == 2'd0) ? ref_alu :
                  (ref_src == 2'd1) ? ref_rdata :
                  (ref_src == 2'd2) ? ref_pc4 : 32'd0;
        check({tag, " ValidW"},     64'(u_if.ValidW),     64'(ref_valid));
        check({tag, " RegWriteW"},  64'(u_if.RegWriteW),
              64'(ref_regwrite && ref_valid && (ref_rd != 5'd0)));
        check({tag, " RdW"},        64'(u_if.RdW),        64'(ref_rd));
        check({tag, " ResultSrcW"}, 64'(u_if.ResultSrcW), 64'(ref_src));
        check({tag, " ResultW"},    64'(u_if.ResultW),    64'(exp_res));
        check({tag, " RetireCnt"},  64'(u_if.RetireCnt),  64'(ref_retired % 64'h1_0000_0000));
        check({tag, " RetireCnt4"}, 64'(u_if4.RetireCnt), 64'(ref_retired % 16));
    endtask

    vec_t vecs[17];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0);

        //          rst flush stall v  rw src alu           rdata         rd     pc4
        //          -> valid rw rd result cnt
        vecs[0]  = mk(1, 0, 0, 1, 1, 2'd0, 32'h0,        32'h0,        5'd5,  32'h0,   0, 0, 5'd0,  32'h0,        0);
        vecs[1]  = mk(1, 0, 0, 1, 1, 2'd0, 32'h0,        32'h0,        5'd5,  32'h0,   0, 0, 5'd0,  32'h0,        0);
        vecs[2]  = mk(0, 0, 0, 1, 1, 2'd0, 32'h1234,     32'hAAAA0001, 5'd5,  32'h100, 1, 1, 5'd5,  32'h1234,     1);
        vecs[3]  = mk(0, 0, 0, 1, 1, 2'd1, 32'h1111,     32'hDEADBEEF, 5'd6,  32'h104, 1, 1, 5'd6,  32'hDEADBEEF, 2);
        vecs[4]  = mk(0, 0, 0, 1, 1, 2'd2, 32'h2222,     32'h3333,     5'd7,  32'h108, 1, 1, 5'd7,  32'h108,      3);
        vecs[5]  = mk(0, 0, 0, 1, 1, 2'd0, 32'h55,       32'h66,       5'd0,  32'h10C, 1, 0, 5'd0,  32'h55,       4);
        vecs[6]  = mk(0, 0, 0, 1, 1, 2'd3, 32'h77,       32'h78,       5'd8,  32'h110, 1, 1, 5'd8,  32'h0,        5);
        vecs[7]  = mk(0, 0, 0, 0, 1, 2'd0, 32'h99,       32'h9A,       5'd9,  32'h114, 0, 0, 5'd9,  32'h99,       5);
        vecs[8]  = mk(0, 0, 0, 1, 1, 2'd0, 32'hA,        32'hA1,       5'd10, 32'h118, 1, 1, 5'd10, 32'hA,        6);
        vecs[9]  = mk(0, 0, 1, 1, 1, 2'd0, 32'hB,        32'hB1,       5'd11, 32'h11C, 1, 1, 5'd10, 32'hA,        6);
        vecs[10] = mk(0, 0, 1, 1, 1, 2'd1, 32'hB2,       32'hB3,       5'd12, 32'h120, 1, 1, 5'd10, 32'hA,        6);
        vecs[11] = mk(0, 0, 1, 0, 0, 2'd2, 32'hB4,       32'hB5,       5'd13, 32'h124, 1, 1, 5'd10, 32'hA,        6);
        vecs[12] = mk(0, 0, 0, 1, 1, 2'd0, 32'hB,        32'hB1,       5'd11, 32'h128, 1, 1, 5'd11, 32'hB,        7);
        vecs[13] = mk(0, 1, 1, 1, 1, 2'd0, 32'hC,        32'hC1,       5'd12, 32'h12C, 0, 0, 5'd0,  32'h0,        7);
        vecs[14] = mk(0, 0, 0, 1, 1, 2'd0, 32'hD,        32'hD1,       5'd13, 32'h130, 1, 1, 5'd13, 32'hD,        8);
        vecs[15] = mk(1, 0, 0, 1, 1, 2'd0, 32'hE0,       32'hE1,       5'd14, 32'h134, 0, 0, 5'd0,  32'h0,        0);
        vecs[16] = mk(0, 0, 0, 1, 1, 2'd0, 32'hE,        32'hE1,       5'd1,  32'h138, 1, 1, 5'd1,  32'hE,        1);

        // Directed table: each row is driven for one edge, then the W outputs are checked.
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].valid, vecs[i].regwrite,
                  vecs[i].src, vecs[i].alu, vecs[i].rdata, vecs[i].rd, vecs[i].pc4);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d ValidW", i),     64'(u_if.ValidW),     64'(vecs[i].exp_valid));
            check($sformatf("vec%0d RegWriteW", i),  64'(u_if.RegWriteW),  64'(vecs[i].exp_regwrite));
            check($sformatf("vec%0d RdW", i),        64'(u_if.RdW),        64'(vecs[i].exp_rd));
            check($sformatf("vec%0d ResultW", i),    64'(u_if.ResultW),    64'(vecs[i].exp_result));
            check($sformatf("vec%0d RetireCnt", i),  64'(u_if.RetireCnt),  64'(vecs[i].exp_cnt));
            check($sformatf("vec%0d RetireCnt4", i), 64'(u_if4.RetireCnt), 64'(vecs[i].exp_cnt[3:0]));
        end

        // Counter wrap: 17 back-to-back valid loads on the 4-bit counter end at 1.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0);
        @(posedge CLK);
        #1;
        for (int i = 1; i <= 17; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'hFFFF_0000 + 32'(i), 32'h5A5A_5A5A,
                  5'd3, 32'h4000 + 32'(4 * i));
            @(posedge CLK);
            #1;
            check($sformatf("wrap%0d RetireCnt4", i), 64'(u_if4.RetireCnt), 64'(i % 16));
            check($sformatf("wrap%0d ResultW", i),    64'(u_if.ResultW),    64'd0);
        end
        check("wrap RetireCnt4 final", 64'(u_if4.RetireCnt), 64'd1);
        check("wrap RetireCnt final",  64'(u_if.RetireCnt),  64'd17);

        // Randomized traffic against the behavioural model, starting from a clean reset.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, '0);
        @(posedge CLK);
        model_edge();
        #1;
        model_compare("rnd reset");
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)),
                  $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom);
            @(posedge CLK);
            model_edge();
            #1;
            model_compare($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
